// File: rtl/nbody_bus_bridge.sv
// Host-bus front end for the n-body core: assembles wide body fields from bus words,
// runs the go/done handshake, keeps status/step counters and serves pipelined readback.
module nbody_bus_bridge #(
  parameter int BUS_WIDTH       = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int NUM_FIELDS      = 5,
  parameter int NUM_OUT_FIELDS  = 2,
  parameter int GAP_WIDTH       = 32,
  parameter int FIELD_BASE      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 chipselect,
  input  logic                                 write,
  input  logic                                 read,
  input  logic [ADDR_WIDTH-1:0]                addr,
  input  logic [BUS_WIDTH-1:0]                 writedata,
  output logic [BUS_WIDTH-1:0]                 readdata,
  output logic                                 ld_valid,
  output logic [((NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1)-1:0] ld_field,
  output logic [BODY_ADDR_WIDTH-1:0]           ld_index,
  output logic [DATA_WIDTH-1:0]                ld_data,
  output logic                                 core_go,
  output logic [BODY_ADDR_WIDTH:0]             core_n_bodies,
  output logic [GAP_WIDTH-1:0]                 core_gap,
  input  logic                                 core_done,
  output logic [BODY_ADDR_WIDTH-1:0]           res_index,
  input  logic [NUM_OUT_FIELDS*DATA_WIDTH-1:0] res_data,
  output logic                                 irq
);

  localparam int FW        = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int WPE       = DATA_WIDTH / BUS_WIDTH;
  localparam int HW        = (WPE > 1) ? $clog2(WPE) : 1;
  localparam int NSTG      = (WPE > 1) ? WPE - 1 : 1;
  localparam int RES_BASE  = 64;
  localparam int RES_WORDS = NUM_OUT_FIELDS * WPE;
  localparam int RW        = (RES_WORDS > 1) ? $clog2(RES_WORDS) : 1;
  localparam int NMAX      = 2 ** BODY_ADDR_WIDTH;
  localparam logic [BUS_WIDTH:0] NMAX_W = (BUS_WIDTH + 1)'(NMAX);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                         state_q;
  logic [BODY_ADDR_WIDTH:0]       nBodies_q;
  logic [GAP_WIDTH-1:0]           gap_q;
  logic [31:0]                    steps_q;
  logic                           irqEn_q;
  logic                           done_q;
  logic                           goOverrun_q;
  logic                           wrErr_q;
  logic                           seqErr_q;
  logic [NSTG*BUS_WIDTH-1:0]      stage_q;
  logic [FW-1:0]                  recField_q;
  logic [BODY_ADDR_WIDTH-1:0]     recIdx_q;
  logic                           ldValid_q;
  logic [FW-1:0]                  ldField_q;
  logic [BODY_ADDR_WIDTH-1:0]     ldIndex_q;
  logic [DATA_WIDTH-1:0]          ldData_q;
  logic                           coreGo_q;

  logic                           rdPend_q;
  logic                           rdRes_q;
  logic [RW-1:0]                  rdWord_q;
  logic [BUS_WIDTH-1:0]           rdReg_q;
  logic [BODY_ADDR_WIDTH-1:0]     resIdx_q;
  logic [BUS_WIDTH-1:0]           readdata_q;

  logic                           wrEn;
  logic                           rdEn;
  logic                           busy;
  logic [31:0]                    selW;
  logic [BODY_ADDR_WIDTH-1:0]     idx;
  logic [31:0]                    fOff;
  logic [31:0]                    rOff;
  logic                           isField;
  logic                           isRes;
  logic [FW-1:0]                  fieldNum;
  logic [HW-1:0]                  wordNum;
  logic [RW-1:0]                  resWord;
  logic [4:0]                     status;
  logic [BUS_WIDTH-1:0]           regVal;
  logic [BODY_ADDR_WIDTH:0]       nBodies_d;
  logic [DATA_WIDTH-1:0]          assembled;

  assign wrEn   = chipselect & write;
  assign rdEn   = chipselect & read;
  assign busy   = (state_q == RUN);
  assign selW   = 32'(addr[ADDR_WIDTH-1:BODY_ADDR_WIDTH]);
  assign idx    = addr[BODY_ADDR_WIDTH-1:0];
  assign status = {seqErr_q, wrErr_q, goOverrun_q, done_q, busy};

  always_comb begin
    isField  = 1'b0;
    isRes    = 1'b0;
    fieldNum = '0;
    wordNum  = '0;
    resWord  = '0;
    fOff     = selW - 32'(FIELD_BASE);
    rOff     = selW - 32'(RES_BASE);
    if (selW >= 32'(FIELD_BASE) && fOff < 32'(NUM_FIELDS * WPE)) begin
      isField  = 1'b1;
      fieldNum = FW'(fOff / 32'(WPE));
      wordNum  = HW'(fOff % 32'(WPE));
    end
    if (selW >= 32'(RES_BASE) && rOff < 32'(RES_WORDS)) begin
      isRes   = 1'b1;
      resWord = RW'(rOff);
    end
  end

  always_comb begin
    case (selW)
      32'd2:   regVal = BUS_WIDTH'(nBodies_q);
      32'd3:   regVal = BUS_WIDTH'(gap_q);
      32'd4:   regVal = BUS_WIDTH'(status);
      32'd5:   regVal = BUS_WIDTH'(steps_q);
      32'd6:   regVal = BUS_WIDTH'(irqEn_q);
      default: regVal = '0;
    endcase
  end

  always_comb begin
    if ({1'b0, writedata} > NMAX_W) nBodies_d = (BODY_ADDR_WIDTH + 1)'(NMAX);
    else                            nBodies_d = (BODY_ADDR_WIDTH + 1)'(writedata);
  end

  // The final word of a field is never staged; it is spliced on top of the staged words.
  generate
    if (WPE == 1) begin : g_single
      assign assembled = DATA_WIDTH'(writedata);
    end else begin : g_multi
      assign assembled = {writedata, stage_q};
    end
  endgenerate

  // Control FSM, register file and field loader. Clears are issued before sets so a
  // same-cycle set event always wins over a write-1-to-clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      nBodies_q   <= '0;
      gap_q       <= '0;
      steps_q     <= '0;
      irqEn_q     <= 1'b0;
      done_q      <= 1'b0;
      goOverrun_q <= 1'b0;
      wrErr_q     <= 1'b0;
      seqErr_q    <= 1'b0;
      stage_q     <= '0;
      recField_q  <= '0;
      recIdx_q    <= '0;
      ldValid_q   <= 1'b0;
      ldField_q   <= '0;
      ldIndex_q   <= '0;
      ldData_q    <= '0;
      coreGo_q    <= 1'b0;
    end else begin
      ldValid_q <= 1'b0;
      coreGo_q  <= 1'b0;

      if (wrEn && selW == 32'd4) begin
        if (writedata[1]) done_q      <= 1'b0;
        if (writedata[2]) goOverrun_q <= 1'b0;
        if (writedata[3]) wrErr_q     <= 1'b0;
        if (writedata[4]) seqErr_q    <= 1'b0;
      end

      if (wrEn && selW == 32'd2) begin
        if (busy) wrErr_q   <= 1'b1;
        else      nBodies_q <= nBodies_d;
      end

      if (wrEn && selW == 32'd3) begin
        if (busy) wrErr_q <= 1'b1;
        else      gap_q   <= GAP_WIDTH'(writedata);
      end

      if (wrEn && selW == 32'd6) irqEn_q <= writedata[0];

      if (wrEn && isField) begin
        if (busy) begin
          wrErr_q <= 1'b1;
        end else if (wordNum == HW'(WPE - 1)) begin
          ldValid_q <= 1'b1;
          ldField_q <= fieldNum;
          ldIndex_q <= idx;
          ldData_q  <= assembled;
          if (WPE > 1 && (fieldNum != recField_q || idx != recIdx_q)) seqErr_q <= 1'b1;
        end else begin
          stage_q[int'(wordNum)*BUS_WIDTH +: BUS_WIDTH] <= writedata;
          if (wordNum == '0) begin
            recField_q <= fieldNum;
            recIdx_q   <= idx;
          end
        end
      end

      if (wrEn && selW == 32'd0) begin
        if (busy) begin
          goOverrun_q <= 1'b1;
        end else if (writedata[0]) begin
          if (nBodies_q != '0) begin
            coreGo_q <= 1'b1;
            state_q  <= RUN;
            done_q   <= 1'b0;
            if (writedata[1]) steps_q <= '0;
          end else begin
            done_q <= 1'b1;
          end
        end
      end

      if (core_done && busy) begin
        state_q <= IDLE;
        done_q  <= 1'b1;
        steps_q <= steps_q + 32'd1;
      end
    end
  end

  // Two-stage read pipeline: register values are snapshotted at the strobe, result
  // words are sliced once the synchronous result RAM has answered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPend_q   <= 1'b0;
      rdRes_q    <= 1'b0;
      rdWord_q   <= '0;
      rdReg_q    <= '0;
      resIdx_q   <= '0;
      readdata_q <= '0;
    end else begin
      rdPend_q <= rdEn;
      if (rdEn) begin
        rdRes_q  <= isRes;
        rdWord_q <= resWord;
        rdReg_q  <= regVal;
        resIdx_q <= idx;
      end
      if (rdPend_q) begin
        if (rdRes_q) readdata_q <= res_data[int'(rdWord_q)*BUS_WIDTH +: BUS_WIDTH];
        else         readdata_q <= rdReg_q;
      end
    end
  end

  assign readdata      = readdata_q;
  assign ld_valid      = ldValid_q;
  assign ld_field      = ldField_q;
  assign ld_index      = ldIndex_q;
  assign ld_data       = ldData_q;
  assign core_go       = coreGo_q;
  assign core_n_bodies = nBodies_q;
  assign core_gap      = gap_q;
  assign res_index     = rdEn ? idx : resIdx_q;
  assign irq           = done_q & irqEn_q;

endmodule

// File: tb/tb_nbody_bus_bridge.sv
// Randomized self-checking bench for nbody_bus_bridge against a register-level
// behavioural model of the bridge plus a synchronous result-RAM stub.
module tb_nbody_bus_bridge;

  localparam int BW   = 32;
  localparam int DW   = 64;
  localparam int AW   = 16;
  localparam int BAW  = 9;
  localparam int NF   = 5;
  localparam int NOF  = 2;
  localparam int GW   = 32;
  localparam int FB   = 8;
  localparam int FW   = 3;
  localparam int WPE  = DW / BW;
  localparam int SW   = AW - BAW;
  localparam int NMAX = 2 ** BAW;
  localparam int RB   = 64;

  logic              clk;
  logic              rst;
  logic              chipselect;
  logic              write;
  logic              read;
  logic [AW-1:0]     addr;
  logic [BW-1:0]     writedata;
  logic [BW-1:0]     readdata;
  logic              ld_valid;
  logic [FW-1:0]     ld_field;
  logic [BAW-1:0]    ld_index;
  logic [DW-1:0]     ld_data;
  logic              core_go;
  logic [BAW:0]      core_n_bodies;
  logic [GW-1:0]     core_gap;
  logic              core_done;
  logic [BAW-1:0]    res_index;
  logic [NOF*DW-1:0] res_data;
  logic              irq;

  nbody_bus_bridge dut (
    .clk(clk), .rst(rst), .chipselect(chipselect), .write(write), .read(read),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .ld_valid(ld_valid), .ld_field(ld_field), .ld_index(ld_index), .ld_data(ld_data),
    .core_go(core_go), .core_n_bodies(core_n_bodies), .core_gap(core_gap),
    .core_done(core_done), .res_index(res_index), .res_data(res_data), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Result memory stub: synchronous read, one cycle of latency.
  logic [NOF*DW-1:0] resMem [NMAX];
  always @(posedge clk) res_data <= resMem[res_index];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Behavioural model of the visible bridge state.
  int            mN;
  logic [GW-1:0] mGap;
  logic [31:0]   mSteps;
  bit            mIrqEn, mBusy, mDone, mOver, mWrErr, mSeqErr;
  logic [BW-1:0] mStage [WPE];
  int            mRecF, mRecIdx;
  int            mLoads;
  int            ldSeen = 0;
  logic [BW-1:0] lastRead;

  always @(negedge clk) if (ld_valid === 1'b1) ldSeen++;

  task automatic modelReset();
    mN = 0; mGap = '0; mSteps = '0;
    mIrqEn = 0; mBusy = 0; mDone = 0; mOver = 0; mWrErr = 0; mSeqErr = 0;
    for (int k = 0; k < WPE; k++) mStage[k] = '0;
    mRecF = 0; mRecIdx = 0;
    lastRead = '0;
  endtask

  task automatic modelWrite(input int sel, input int idx, input logic [BW-1:0] wd,
                            output bit commit, output int cf, output int ci,
                            output logic [DW-1:0] cd, output bit go);
    int off, f, h;
    commit = 0; go = 0; cf = 0; ci = 0; cd = '0;
    off = sel - FB;
    if (sel == 0) begin
      if (mBusy) mOver = 1;
      else if (wd[0]) begin
        if (mN > 0) begin
          go = 1; mBusy = 1; mDone = 0;
          if (wd[1]) mSteps = '0;
        end else mDone = 1;
      end
    end else if (sel == 2) begin
      if (mBusy) mWrErr = 1;
      else mN = (wd > NMAX) ? NMAX : int'(wd);
    end else if (sel == 3) begin
      if (mBusy) mWrErr = 1;
      else mGap = wd;
    end else if (sel == 4) begin
      if (wd[1]) mDone = 0;
      if (wd[2]) mOver = 0;
      if (wd[3]) mWrErr = 0;
      if (wd[4]) mSeqErr = 0;
    end else if (sel == 6) begin
      mIrqEn = wd[0];
    end else if (off >= 0 && off < NF * WPE) begin
      f = off / WPE;
      h = off % WPE;
      if (mBusy) mWrErr = 1;
      else if (h == WPE - 1) begin
        commit = 1; cf = f; ci = idx; cd = DW'(wd);
        for (int k = WPE - 2; k >= 0; k--) cd = (cd << BW) | DW'(mStage[k]);
        if (WPE > 1 && (f != mRecF || idx != mRecIdx)) mSeqErr = 1;
        mLoads++;
      end else begin
        mStage[h] = wd;
        if (h == 0) begin mRecF = f; mRecIdx = idx; end
      end
    end
  endtask

  task automatic modelDone(input bit wasBusy);
    if (wasBusy) begin
      mBusy = 0; mDone = 1; mSteps = mSteps + 32'd1;
    end
  endtask

  function automatic logic [BW-1:0] modelRead(input int sel, input int idx);
    logic [NOF*DW-1:0] tmp;
    int off;
    off = sel - RB;
    if (off >= 0 && off < NOF * WPE) begin
      tmp = resMem[idx] >> (off * BW);
      return tmp[BW-1:0];
    end
    case (sel)
      2: return BW'(mN);
      3: return BW'(mGap);
      4: return BW'({mSeqErr, mWrErr, mOver, mDone, mBusy});
      5: return BW'(mSteps);
      6: return BW'(mIrqEn);
      default: return '0;
    endcase
  endfunction

  task automatic checkState();
    checkOutput("n_bodies", core_n_bodies, mN);
    checkOutput("gap", core_gap, mGap);
    checkOutput("irq", irq, mDone & mIrqEn);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_readdata"}, readdata, 0);
    checkOutput({tag, "_ld_valid"}, ld_valid, 0);
    checkOutput({tag, "_ld_field"}, ld_field, 0);
    checkOutput({tag, "_ld_index"}, ld_index, 0);
    checkOutput({tag, "_ld_data"}, ld_data, 0);
    checkOutput({tag, "_core_go"}, core_go, 0);
    checkOutput({tag, "_n_bodies"}, core_n_bodies, 0);
    checkOutput({tag, "_gap"}, core_gap, 0);
    checkOutput({tag, "_res_index"}, res_index, 0);
    checkOutput({tag, "_irq"}, irq, 0);
  endtask

  // One bus write (optionally with core_done in the same cycle), then pulse checks.
  task automatic applyStimulus(input int sel, input int idx, input logic [BW-1:0] wd, input bit withDone);
    bit commit, go, wasBusy;
    int cf, ci;
    logic [DW-1:0] cd;
    @(negedge clk);
    chipselect = 1; write = 1; writedata = wd; core_done = withDone;
    addr = {SW'(sel), BAW'(idx)};
    wasBusy = mBusy;
    modelWrite(sel, idx, wd, commit, cf, ci, cd, go);
    if (withDone) modelDone(wasBusy);
    @(negedge clk);
    chipselect = 0; write = 0; core_done = 0;
    checkOutput("ld_valid", ld_valid, commit);
    checkOutput("core_go", core_go, go);
    if (commit) begin
      checkOutput("ld_field", ld_field, cf);
      checkOutput("ld_index", ld_index, ci);
      checkOutput("ld_data", ld_data, cd);
    end
    @(negedge clk);
    checkOutput("ld_pulse", ld_valid, 0);
    checkOutput("go_pulse", core_go, 0);
    checkState();
  endtask

  task automatic pulseDone();
    bit wasBusy;
    @(negedge clk);
    core_done = 1;
    wasBusy = mBusy;
    modelDone(wasBusy);
    @(negedge clk);
    core_done = 0;
    checkState();
  endtask

  int bSel[$];
  int bIdx[$];

  // Issues the queued reads back to back and checks each result two cycles later.
  task automatic readBurst();
    logic [BW-1:0] expQ[$];
    int n;
    n = bSel.size();
    for (int c = 0; c < n + 2; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        lastRead = expQ.pop_front();
        checkOutput("readdata", readdata, lastRead);
      end
      if (c < n) begin
        chipselect = 1; read = 1;
        addr = {SW'(bSel[c]), BAW'(bIdx[c])};
        expQ.push_back(modelRead(bSel[c], bIdx[c]));
        #1 checkOutput("res_index", res_index, bIdx[c]);
      end else begin
        chipselect = 0; read = 0;
      end
    end
    @(negedge clk);
    checkOutput("rd_hold", readdata, lastRead);
    bSel.delete();
    bIdx.delete();
  endtask

  task automatic busRead(input int sel, input int idx);
    bSel.push_back(sel);
    bIdx.push_back(idx);
    readBurst();
  endtask

  function automatic int randSel();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return $urandom_range(0, 127);
    if (r == 1) return $urandom_range(RB, RB + NOF * WPE - 1);
    if (r == 2) return $urandom_range(2, 6);
    return $urandom_range(0, 20);
  endfunction

  initial begin
    rst = 1; chipselect = 0; write = 0; read = 0; addr = '0; writedata = '0; core_done = 0;
    mLoads = 0;
    modelReset();
    for (int i = 0; i < NMAX; i++) resMem[i] = {$urandom, $urandom, $urandom, $urandom};

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 0;
    @(negedge clk);
    checkAllZero("post_reset");

    // Single field load of x for body 3.
    applyStimulus(8, 3, 32'h0, 0);
    applyStimulus(9, 3, 32'h40340000, 0);

    // Index changes between halves: commit on new index, seq_err raised then cleared.
    applyStimulus(8, 3, 32'h11111111, 0);
    applyStimulus(9, 4, 32'h22222222, 0);
    busRead(4, 0);
    checkOutput("seq_err_status", lastRead, 32'h10);
    applyStimulus(4, 0, 32'h10, 0);
    busRead(4, 0);

    // Saturation, run, overrun, done, steps, irq.
    applyStimulus(2, 0, 32'd1000, 0);
    busRead(2, 0);
    checkOutput("nmax_sat", lastRead, NMAX);
    applyStimulus(6, 0, 32'h1, 0);
    applyStimulus(0, 0, 32'h1, 0);
    busRead(4, 0);
    applyStimulus(0, 0, 32'h1, 0);
    applyStimulus(8, 1, 32'h5, 0);
    applyStimulus(3, 0, 32'd7, 0);
    pulseDone();
    busRead(4, 0);
    busRead(5, 0);
    applyStimulus(4, 0, 32'h1E, 0);
    pulseDone();

    // GO with no bodies only raises done.
    applyStimulus(2, 0, 32'd0, 0);
    applyStimulus(0, 0, 32'h1, 0);
    busRead(4, 0);

    // core_done coincident with a done clear: done survives.
    applyStimulus(2, 0, 32'd5, 0);
    applyStimulus(0, 0, 32'h3, 0);
    applyStimulus(4, 0, 32'h2, 1);
    busRead(4, 0);

    // Back-to-back result reads.
    resMem[2] = {DW'({$urandom, $urandom}), 64'hC014000000000000};
    bSel.push_back(RB);     bIdx.push_back(2);
    bSel.push_back(RB + 1); bIdx.push_back(2);
    readBurst();
    checkOutput("res_x_hi", lastRead, 32'hC0140000);

    // Reset in the middle of a run with half a field staged and a read in flight.
    applyStimulus(4, 0, 32'h1E, 0);
    applyStimulus(8, 5, $urandom, 0);
    applyStimulus(0, 0, 32'h1, 0);
    @(negedge clk);
    chipselect = 1; read = 1; addr = {SW'(5), BAW'(0)};
    @(negedge clk);
    chipselect = 0; read = 0;
    #2 rst = 1;
    #1 checkAllZero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("discarded_read", readdata, 0);
    applyStimulus(9, 0, 32'hDEADBEEF, 0);
    busRead(4, 0);

    // Randomized phase.
    for (int it = 0; it < 400; it++) begin
      int r, f, h, idx;
      r = $urandom_range(0, 99);
      if (r < 40) begin
        f   = ($urandom_range(0, 9) < 6) ? mRecF : $urandom_range(0, NF - 1);
        idx = ($urandom_range(0, 9) < 6) ? mRecIdx : $urandom_range(0, NMAX - 1);
        h   = $urandom_range(0, WPE - 1);
        applyStimulus(FB + f * WPE + h, idx, $urandom, 0);
      end else if (r < 50) begin
        applyStimulus(2, $urandom_range(0, NMAX - 1), ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 1100), 0);
      end else if (r < 55) begin
        applyStimulus(3, 0, $urandom_range(0, 512), 0);
      end else if (r < 62) begin
        applyStimulus(0, 0, $urandom_range(0, 3), 0);
      end else if (r < 72) begin
        pulseDone();
      end else if (r < 77) begin
        applyStimulus(4, 0, BW'($urandom_range(0, 31)), 0);
      end else if (r < 80) begin
        applyStimulus(6, 0, $urandom, 0);
      end else if (r < 95) begin
        busRead(randSel(), $urandom_range(0, NMAX - 1));
      end else begin
        for (int k = 0; k < int'($urandom_range(3, 8)); k++) begin
          bSel.push_back(randSel());
          bIdx.push_back($urandom_range(0, NMAX - 1));
        end
        readBurst();
      end
    end

    repeat (2) @(negedge clk);
    checkOutput("load_count", ldSeen, mLoads);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
